// File: rtl/mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mult_ctrl
//  Purpose  : Sequencing controller between the execute stage and the
//             multserial serial multiplier. Accepts MULT/MULTU, latches the
//             operands, issues a one-cycle start, waits for the product and
//             commits it to the architectural HI/LO registers. Stalls any
//             HI/LO access or second multiply while a multiply is in flight,
//             handles MTHI/MTLO and aborts via a watchdog if no product
//             arrives in time.
//  Ports    : clk, rst (async, active-low)
//             ex_mult/ex_sgn/ex_a/ex_b       - multiply request from execute
//             ex_mfhi/ex_mflo/ex_mthi/ex_mtlo/ex_wd - HI/LO moves
//             stall (comb), hi, lo, busy, err - pipeline-facing outputs
//             m_st/m_sgn/m_a/m_b             - multserial launch interface
//             m_prod/m_prodv                 - multserial product return
//  Revision : 1.0 - initial release
// ============================================================================
module mult_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mult,
  input  logic        ex_sgn,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  input  logic        ex_mfhi,
  input  logic        ex_mflo,
  input  logic        ex_mthi,
  input  logic        ex_mtlo,
  input  logic [31:0] ex_wd,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        err,
  output logic        m_st,
  output logic        m_sgn,
  output logic [31:0] m_a,
  output logic [31:0] m_b,
  input  logic [63:0] m_prod,
  input  logic        m_prodv
);

  // Counter only has to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_BUSY   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [31:0]   hi_q,    hi_d;
  logic [31:0]   lo_q,    lo_d;
  logic [31:0]   m_a_q,   m_a_d;
  logic [31:0]   m_b_q,   m_b_d;
  logic          m_sgn_q, m_sgn_d;
  logic          err_q,   err_d;

  logic          w_cnt_last;
  logic          w_ex_any;

  assign w_cnt_last = (cnt_q == C_CNT_LAST);
  assign w_ex_any   = ex_mult | ex_mfhi | ex_mflo | ex_mthi | ex_mtlo;

  // --------------------------------------------------------------------------
  // State register and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      m_a_q   <= '0;
      m_b_q   <= '0;
      m_sgn_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_a_q   <= m_a_d;
      m_b_q   <= m_b_d;
      m_sgn_q <= m_sgn_d;
      err_q   <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (ex_mult) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_BUSY;
      // A product and a watchdog expiry in the same cycle: the product wins
      // and both paths lead back to IDLE anyway.
      S_BUSY:   if (m_prodv || w_cnt_last) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next-value logic
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_a_d   = m_a_q;
    m_b_d   = m_b_q;
    m_sgn_d = m_sgn_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (ex_mult) begin
          // Operands stay frozen from here until the next accepted MULT.
          m_a_d   = ex_a;
          m_b_d   = ex_b;
          m_sgn_d = ex_sgn;
        end else begin
          // A move decoded together with a MULT is dropped.
          if (ex_mthi) hi_d = ex_wd;
          if (ex_mtlo) lo_d = ex_wd;
        end
      end
      S_LAUNCH: begin
        // m_prodv is deliberately ignored here: it may still be asserted
        // for the previous product.
        cnt_d = '0;
      end
      S_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (m_prodv) begin
          hi_d = m_prod[63:32];
          lo_d = m_prod[31:0];
        end else if (w_cnt_last) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    m_st  = (state_q == S_LAUNCH);
    busy  = (state_q != S_IDLE);
    stall = (state_q != S_IDLE) & w_ex_any;
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign err   = err_q;
  assign m_a   = m_a_q;
  assign m_b   = m_b_q;
  assign m_sgn = m_sgn_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mult_ctrl
//  Purpose  : Self-checking bench for mult_ctrl with a behavioural stand-in
//             for the serial multiplier and an operation-level HI/LO model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_ctrl;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mult, ex_sgn, ex_mfhi, ex_mflo, ex_mthi, ex_mtlo;
  logic [31:0] ex_a, ex_b, ex_wd;
  logic        stall, busy, err, m_st, m_sgn, m_prodv;
  logic [31:0] hi, lo, m_a, m_b;
  logic [63:0] m_prod;

  always #5 clk = ~clk;

  mult_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ex_mult(ex_mult), .ex_sgn(ex_sgn), .ex_a(ex_a), .ex_b(ex_b),
    .ex_mfhi(ex_mfhi), .ex_mflo(ex_mflo), .ex_mthi(ex_mthi), .ex_mtlo(ex_mtlo),
    .ex_wd(ex_wd), .stall(stall), .hi(hi), .lo(lo), .busy(busy), .err(err),
    .m_st(m_st), .m_sgn(m_sgn), .m_a(m_a), .m_b(m_b),
    .m_prod(m_prod), .m_prodv(m_prodv)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full 64-bit product from the ISA definition of MULT/MULTU.
  function automatic logic [63:0] ref_prod(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    return 64'(sa * sb);
  endfunction

  // ---------------- serial multiplier stand-in ----------------
  bit          model_en  = 1'b1;
  bit          stale_en  = 1'b0;
  int          model_lat = 2;
  int          mcnt      = 0;
  logic [31:0] cap_a, cap_b;
  logic        cap_s;

  initial begin
    m_prodv = 1'b0;
    m_prod  = '0;
    cap_a = '0; cap_b = '0; cap_s = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_prodv = 1'b0;
      if (m_st) begin
        cap_a = m_a; cap_b = m_b; cap_s = m_sgn;
        mcnt  = model_lat;
        if (stale_en) begin
          // Leftover valid from an earlier product, carrying junk.
          m_prodv = 1'b1;
          m_prod  = 64'hDEAD_BEEF_0BAD_F00D;
        end
      end else if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0 && model_en) begin
          m_prodv = 1'b1;
          m_prod  = ref_prod(cap_s, cap_a, cap_b);
        end
      end
    end
  end

  // ---------------- start-pulse monitor ----------------
  int   st_cnt  = 0;
  int   st_adj  = 0;
  logic st_prev = 1'b0;
  always @(negedge clk) begin
    if (m_st) st_cnt++;
    if (m_st && st_prev) st_adj++;
    st_prev = m_st;
  end

  // ---------------- operation-level HI/LO model ----------------
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  int          n_launch = 0;

  task automatic idle_inputs();
    ex_mult = 0; ex_sgn = 0; ex_a = '0; ex_b = '0;
    ex_mfhi = 0; ex_mflo = 0; ex_mthi = 0; ex_mtlo = 0; ex_wd = '0;
  endtask

  task automatic drain(input string name);
    int g = 0;
    while (busy && g < 300) begin @(negedge clk); #1; g++; end
    chk(name, 64'(busy), 64'd0);
  endtask

  // Presents one instruction, holds it while stalled, checks reads at the
  // cycle it is accepted and advances the model in program order.
  task automatic issue(input logic mult, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic mfhi, input logic mflo, input logic mthi, input logic mtlo,
                       input logic [31:0] wd);
    int g = 0;
    @(negedge clk);
    ex_mult = mult; ex_sgn = sgn; ex_a = a; ex_b = b;
    ex_mfhi = mfhi; ex_mflo = mflo; ex_mthi = mthi; ex_mtlo = mtlo; ex_wd = wd;
    #1;
    while (stall && g < 300) begin @(negedge clk); #1; g++; end
    chk("issue_stall_bound", 64'(stall), 64'd0);
    if (mfhi) chk("rnd_mfhi", 64'(hi), 64'(exp_hi));
    if (mflo) chk("rnd_mflo", 64'(lo), 64'(exp_lo));
    if (mult) begin
      {exp_hi, exp_lo} = ref_prod(sgn, a, b);
      n_launch++;
    end else begin
      if (mthi) exp_hi = wd;
      if (mtlo) exp_lo = wd;
    end
  endtask

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int st_before, g, n;
    logic err_early;

    tbl[0] = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
    tbl[1] = '{1'b0, 32'h00000001, 32'h40000000, 32'h00000000, 32'h40000000};
    tbl[2] = '{1'b1, 32'h00000001, 32'h40000000, 32'h00000000, 32'h40000000};
    tbl[3] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[4] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    tbl[5] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tbl[6] = '{1'b0, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    tbl[7] = '{1'b1, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000};

    rst = 1'b0;
    idle_inputs();

    // ---- reset state ----
    @(negedge clk); ex_mfhi = 1; #1;
    chk("rst_hi", 64'(hi), 64'd0);   chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0); chk("rst_err", 64'(err), 64'd0);
    chk("rst_mst", 64'(m_st), 64'd0); chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_ma", 64'(m_a), 64'd0);  chk("rst_msgn", 64'(m_sgn), 64'd0);
    @(negedge clk); idle_inputs(); rst = 1'b1; #1;

    // ---- table-driven multiplies ----
    for (int i = 0; i < 8; i++) begin
      model_lat = 1 + (i % 4);
      stale_en  = (i % 2) == 1;
      st_before = st_cnt;
      @(negedge clk);
      ex_mult = 1; ex_sgn = tbl[i].sgn; ex_a = tbl[i].a; ex_b = tbl[i].b; #1;
      chk("tbl_no_stall", 64'(stall), 64'd0);
      @(negedge clk); idle_inputs(); #1;
      chk("tbl_mst", 64'(m_st), 64'd1);
      chk("tbl_msgn", 64'(m_sgn), 64'(tbl[i].sgn));
      chk("tbl_ma", 64'(m_a), 64'(tbl[i].a));
      chk("tbl_mb", 64'(m_b), 64'(tbl[i].b));
      drain("tbl_drain");
      chk("tbl_hi", 64'(hi), 64'(tbl[i].hi));
      chk("tbl_lo", 64'(lo), 64'(tbl[i].lo));
      chk("tbl_ma_hold", 64'(m_a), 64'(tbl[i].a));
      chk("tbl_one_pulse", 64'(st_cnt - st_before), 64'd1);
      exp_hi = tbl[i].hi; exp_lo = tbl[i].lo; n_launch++;
    end
    stale_en = 1'b0;

    // ---- MULT then MFHI: stall through the product cycle ----
    model_lat = 3;
    @(negedge clk); ex_mult = 1; ex_sgn = 1; ex_a = 32'hFFFFFFFE; ex_b = 32'h3; #1;
    chk("mf_mult_no_stall", 64'(stall), 64'd0);
    @(negedge clk); idle_inputs(); ex_mfhi = 1; #1;
    chk("mf_launch_stall", 64'(stall), 64'd1);
    g = 0;
    do begin
      @(negedge clk); #1; g++;
      chk("mf_stall_busy", 64'(stall), 64'd1);
    end while (!m_prodv && g < 50);
    chk("mf_prodv_seen", 64'(m_prodv), 64'd1);
    @(negedge clk); #1;
    chk("mf_stall_released", 64'(stall), 64'd0);
    chk("mf_new_hi", 64'(hi), 64'hFFFFFFFF);
    @(negedge clk); idle_inputs(); ex_mtlo = 1; ex_wd = 32'h12345678; #1;
    chk("mtlo_no_stall", 64'(stall), 64'd0);
    @(negedge clk); idle_inputs(); #1;
    chk("mtlo_lo", 64'(lo), 64'h12345678);
    chk("mtlo_hi_kept", 64'(hi), 64'hFFFFFFFF);
    exp_hi = 32'hFFFFFFFF; exp_lo = 32'h12345678; n_launch++;

    // ---- back-to-back MULTs ----
    model_lat = 4;
    st_before = st_cnt;
    @(negedge clk); ex_mult = 1; ex_sgn = 0; ex_a = 32'h00010000; ex_b = 32'h00010000; #1;
    chk("b2b_first_no_stall", 64'(stall), 64'd0);
    @(negedge clk); ex_sgn = 1; ex_a = 32'hFFFFFFFF; ex_b = 32'h7; #1;
    chk("b2b_second_held", 64'(stall), 64'd1);
    g = 0;
    while (stall && g < 100) begin @(negedge clk); #1; g++; end
    chk("b2b_release_idle", 64'(busy), 64'd0);
    chk("b2b_first_hi", 64'(hi), 64'd1);
    chk("b2b_first_lo", 64'(lo), 64'd0);
    @(negedge clk); idle_inputs(); #1;
    chk("b2b_second_mst", 64'(m_st), 64'd1);
    chk("b2b_second_ma", 64'(m_a), 64'hFFFFFFFF);
    drain("b2b_drain");
    chk("b2b_hi", 64'(hi), 64'hFFFFFFFF);
    chk("b2b_lo", 64'(lo), 64'hFFFFFFF9);
    chk("b2b_two_pulses", 64'(st_cnt - st_before), 64'd2);
    exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFF9; n_launch += 2;

    // ---- watchdog: multiplier never answers ----
    model_en = 1'b0;
    @(negedge clk); ex_mult = 1; ex_sgn = 0; ex_a = 32'h2; ex_b = 32'h3; #1;
    @(negedge clk); idle_inputs(); #1;
    chk("wd_mst", 64'(m_st), 64'd1);
    n = 0; err_early = 1'b0;
    while (busy && n < 200) begin
      err_early = err_early | err;
      n++;
      @(negedge clk); #1;
    end
    chk("wd_busy_cycles", 64'(n), 64'd65);
    chk("wd_err_not_early", 64'(err_early), 64'd0);
    chk("wd_err_set", 64'(err), 64'd1);
    chk("wd_hi_kept", 64'(hi), 64'(exp_hi));
    chk("wd_lo_kept", 64'(lo), 64'(exp_lo));
    n_launch++;
    model_en = 1'b1;
    issue(0, 0, '0, '0, 0, 0, 1, 0, 32'hA5A5A5A5);
    @(negedge clk); idle_inputs(); #1;
    chk("wd_mthi_hi", 64'(hi), 64'hA5A5A5A5);
    chk("wd_err_sticky", 64'(err), 64'd1);

    // ---- reset mid-multiply, then a late product ----
    model_lat = 20;
    @(negedge clk); ex_mult = 1; ex_sgn = 1; ex_a = 32'h1234; ex_b = 32'h5678; #1;
    @(negedge clk); idle_inputs();
    repeat (5) @(negedge clk);
    #1;
    chk("rm_busy_before", 64'(busy), 64'd1);
    @(negedge clk); rst = 1'b0; ex_mfhi = 1; #1;
    chk("rm_hi", 64'(hi), 64'd0);     chk("rm_lo", 64'(lo), 64'd0);
    chk("rm_ma", 64'(m_a), 64'd0);    chk("rm_mb", 64'(m_b), 64'd0);
    chk("rm_msgn", 64'(m_sgn), 64'd0); chk("rm_mst", 64'(m_st), 64'd0);
    chk("rm_err", 64'(err), 64'd0);   chk("rm_busy", 64'(busy), 64'd0);
    chk("rm_stall", 64'(stall), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1; idle_inputs(); #1;
    g = 0;
    while (!m_prodv && g < 40) begin @(negedge clk); #1; g++; end
    chk("rm_late_prodv_seen", 64'(m_prodv), 64'd1);
    @(negedge clk); #1;
    chk("rm_late_hi", 64'(hi), 64'd0);
    chk("rm_late_lo", 64'(lo), 64'd0);
    chk("rm_late_busy", 64'(busy), 64'd0);
    exp_hi = '0; exp_lo = '0; n_launch++;

    // ---- randomized instruction stream against the model ----
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra, rb, rw;
      logic        rs;
      int          k;
      k  = int'($urandom_range(0, 6));
      ra = $urandom; rb = $urandom; rw = $urandom;
      rs = 1'($urandom_range(0, 1));
      model_lat = int'($urandom_range(1, 8));
      stale_en  = ($urandom_range(0, 1) == 1);
      case (k)
        0, 1: issue(1, rs, ra, rb, 0, 0, 0, 0, '0);
        2:    issue(0, 0, '0, '0, 0, 0, 1, 0, rw);
        3:    issue(0, 0, '0, '0, 0, 0, 0, 1, rw);
        4:    issue(0, 0, '0, '0, 0, 0, 1, 1, rw);
        5:    issue(0, 0, '0, '0, 1, 1, 0, 0, '0);
        default: issue(1, rs, ra, rb, 0, 0, 1, 1, rw);
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk); idle_inputs();
      end
    end
    @(negedge clk); idle_inputs(); #1;
    drain("rnd_drain");
    issue(0, 0, '0, '0, 1, 1, 0, 0, '0);
    @(negedge clk); idle_inputs(); #1;
    chk("final_hi", 64'(hi), 64'(exp_hi));
    chk("final_lo", 64'(lo), 64'(exp_lo));
    chk("launch_count", 64'(st_cnt), 64'(n_launch));
    chk("no_adjacent_mst", 64'(st_adj), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire

// File: doc/mult_ctrl.md
# mult_ctrl

Sequencing controller between the pipeline's execute stage and the `multserial` serial multiplier. It accepts MULT/MULTU requests, latches operands, and issues a single-cycle start to `multserial`. It then waits for `prodv`, commits the 64-bit product into architectural HI/LO registers, and generates the pipeline stall for any HI/LO-dependent instruction or second multiply issued while a multiply is in flight. It also handles MTHI/MTLO writes and a watchdog on the multiplier.

## Interface
- `TIMEOUT`, default 64: maximum cycles spent in BUSY waiting for `m_prodv` before abort.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ex_mult`  in  1  execute-stage MULT/MULTU valid.
- `ex_sgn`  in  1  1 = MULT (signed), 0 = MULTU.
- `ex_a`, `ex_b`  in  32  multiply operands.
- `ex_mfhi`, `ex_mflo`  in  1  execute-stage read of HI/LO.
- `ex_mthi`, `ex_mtlo`  in  1  execute-stage write of HI/LO.
- `ex_wd`  in  32  write data for MTHI/MTLO.
- `stall`  out  1  hold execute stage; combinational.
- `hi`, `lo`  out  32  architectural HI/LO registers.
- `busy`  out  1  multiply in flight (state ≠ IDLE).
- `err`  out  1  sticky watchdog timeout flag.
- `m_st`  out  1  start pulse to `multserial`.
- `m_sgn`  out  1  signed-mode select to `multserial`.
- `m_a`, `m_b`  out  32  operands to `multserial`, registered.
- `m_prod`  in  64  product from `multserial`.
- `m_prodv`  in  1  product valid from `multserial`.

## Operation
- States:
  - IDLE: no multiply in flight.
  - LAUNCH: one cycle; `m_st` = 1.
  - BUSY: waiting for `m_prodv`.
- IDLE, `ex_mult` = 1:
  - latch `ex_a`, `ex_b`, `ex_sgn` into `m_a`, `m_b`, `m_sgn`.
  - go to LAUNCH.
  - the MULT itself does not stall.
- LAUNCH:
  - `m_st` = 1 for exactly this cycle.
  - clear watchdog counter.
  - go to BUSY.
  - `m_prodv` is ignored in LAUNCH, because it may be stale from the previous product.
- BUSY:
  - counter increments each cycle.
  - first cycle with `m_prodv` = 1: `hi` ← `m_prod[63:32]`, `lo` ← `m_prod[31:0]`; go to IDLE.
  - if the counter reaches TIMEOUT-1 with no `m_prodv`: set `err`, leave `hi`/`lo` unchanged, go to IDLE.
- `m_a`, `m_b`, `m_sgn` hold their values from launch until the next accepted MULT. `multserial` therefore sees stable operands throughout.
- `stall` = (state ≠ IDLE) & (`ex_mult` | `ex_mfhi` | `ex_mflo` | `ex_mthi` | `ex_mtlo`). The pipeline holds all `ex_*` inputs stable while `stall` = 1.
- In IDLE, MTHI/MTLO write `ex_wd` into `hi`/`lo` at the clock edge.
- In IDLE, MFHI/MFLO read `hi`/`lo` directly; no stall.
- `ex_mult` together with `ex_mthi` or `ex_mtlo` (illegal decode): MULT wins, the move is dropped.
- `ex_mthi` and `ex_mtlo` together: both are written.
- `err` clears only on reset.
- Arithmetic is performed entirely in `multserial`. The controller does no sign handling beyond forwarding `m_sgn`.

## Timing
- Reset (`rst` = 0, asynchronous) forces:
  - state IDLE; `hi` = `lo` = 0.
  - `m_a` = `m_b` = 0; `m_sgn` = 0; `m_st` = 0.
  - `err` = 0; `busy` = 0; counter = 0.
- `stall` = 0 during reset.
- Reset mid-multiply aborts the operation. `hi`/`lo` go to 0, and any later `m_prodv` is ignored until a new LAUNCH.
- MULT accepted at edge of cycle N → `m_st` high in cycle N+1 → BUSY from N+2.
- `m_prodv` high in cycle P → `hi`/`lo` updated at the end of P → a stalled MFHI/MFLO sees `stall` = 1 in P and 0 in P+1, reading the new value.
- Back-to-back MULT: the second MULT stalls until IDLE, is accepted in the first IDLE cycle, and its `m_st` follows one cycle later.
- `m_st` is never high for two consecutive cycles.
- `busy` is registered (state ≠ IDLE); `stall` is combinational.

## Test plan
- Signed MULT 0x7FFFFFFF × 0x80000000 → exactly one `m_st` pulse, `m_sgn` = 1; after `m_prodv`, `hi` = 0xC0000000, `lo` = 0x80000000.
- MULTU 0x00000001 × 0x40000000, then MULT with the same operands → `hi` = 0, `lo` = 0x40000000 both times; `m_sgn` = 0, then 1.
- MULT then MFHI the next cycle → `stall` = 1 from that cycle through the `m_prodv` cycle, 0 the cycle after; MFHI returns the new `hi`; an MTLO of 0x12345678 issued in IDLE → `lo` = 0x12345678 next cycle, no stall.
- Two MULTs back-to-back → second held by `stall`; `m_st` pulses exactly twice, never adjacent; final `hi`/`lo` match the second product.
- Bench multiplier never raises `m_prodv`, TIMEOUT = 64 → `err` = 1 after 64 BUSY cycles, state IDLE, `hi`/`lo` unchanged, `err` held until reset.
- `rst` asserted in the middle of BUSY, then a late `m_prodv` pulse → all outputs at reset values; `hi` = `lo` = 0, unaffected by the late `m_prodv`.
